// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU/MDU control codes, ALUOP/FUNC7 constants and FSM states
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_OR     = 5'b00001;
    localparam logic [4:0] ALU_ADD    = 5'b00010;
    localparam logic [4:0] ALU_SUB    = 5'b00011;
    localparam logic [4:0] ALU_SLL    = 5'b00100;
    localparam logic [4:0] ALU_SLT    = 5'b00101;
    localparam logic [4:0] ALU_SLTU   = 5'b00110;
    localparam logic [4:0] ALU_XOR    = 5'b00111;
    localparam logic [4:0] ALU_SRL    = 5'b01000;
    localparam logic [4:0] ALU_SRA    = 5'b01001;
    localparam logic [4:0] ALU_MUL    = 5'b01010;
    localparam logic [4:0] ALU_MULH   = 5'b01011;
    localparam logic [4:0] ALU_MULHSU = 5'b01100;
    localparam logic [4:0] ALU_MULHU  = 5'b01101;
    localparam logic [4:0] ALU_DIV    = 5'b01110;
    localparam logic [4:0] ALU_DIVU   = 5'b01111;
    localparam logic [4:0] ALU_REM    = 5'b10000;
    localparam logic [4:0] ALU_REMU   = 5'b10001;
    localparam logic [4:0] ALU_INV    = 5'b11111;

    localparam logic [2:0] ALUOP_R    = 3'b000;
    localparam logic [2:0] ALUOP_LOAD = 3'b001;
    localparam logic [2:0] ALUOP_JALR = 3'b010;
    localparam logic [2:0] ALUOP_IMM  = 3'b011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_t;

    function automatic logic is_mdu_code(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative restoring radix-2 divider, one quotient bit per cycle
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q_r, r_r, d_r;
    logic            neg_q, neg_r, by_zero;

    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] q_next, r_next;

    assign a_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

    // Partial remainder stays below the divisor, so bit XLEN of trial is a clean borrow flag.
    assign shifted = {r_r, q_r[XLEN-1]};
    assign trial   = shifted - {1'b0, d_r};
    assign r_next  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign q_next  = {q_r[XLEN-2:0], ~trial[XLEN]};

    assign done = busy && (cnt == LAST);
    assign quot = by_zero ? '1 : (neg_q ? -q_next : q_next);
    assign rem  = neg_r ? -r_next : r_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            q_r     <= '0;
            r_r     <= '0;
            d_r     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            q_r     <= a_mag;
            r_r     <= '0;
            d_r     <= b_mag;
            neg_q   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r   <= is_signed && dividend[XLEN-1];
            by_zero <= (divisor == '0);
        end else if (busy) begin
            q_r <= q_next;
            r_r <= r_next;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// rtl/alu_mdu_ctrl.sv - RV32IM EX-stage ALU decode with multi-cycle MUL/DIV sequencing and stall
module alu_mdu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int M_EXT      = 1,
    parameter int DIV_SHORT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [2:0]      aluop,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [4:0]      alu_ctrl,
    output logic            md_stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);
    localparam logic [1:0] MUL_LAST = (MUL_STAGES >= 2) ? 2'(MUL_STAGES - 2) : 2'd0;

    md_state_t       state, state_nx;
    logic [1:0]      mul_cnt;
    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;

    always_comb begin
        alu_ctrl = ALU_INV;
        case (aluop)
            ALUOP_R: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        3'b000:  alu_ctrl = ALU_ADD;
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b101:  alu_ctrl = ALU_SRL;
                        3'b110:  alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end else if (func7 == F7_ALT) begin
                    if (func3 == 3'b000)      alu_ctrl = ALU_SUB;
                    else if (func3 == 3'b101) alu_ctrl = ALU_SRA;
                end else if (func7 == F7_MULDIV && M_EXT != 0) begin
                    alu_ctrl = ALU_MUL + {2'b00, func3};
                end
            end
            ALUOP_LOAD, ALUOP_JALR: alu_ctrl = ALU_ADD;
            ALUOP_IMM: begin
                case (func3)
                    3'b000: alu_ctrl = ALU_ADD;
                    3'b001: if (func7 == F7_BASE) alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: begin
                        if (func7 == F7_BASE)     alu_ctrl = ALU_SRL;
                        else if (func7 == F7_ALT) alu_ctrl = ALU_SRA;
                    end
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_INV;
        endcase
    end

    logic mdu_op, accept, is_mul, div_signed, want_rem, div_zero, div_ovf, short_cut;
    logic [XLEN-1:0] short_val;

    assign mdu_op     = valid_in && is_mdu_code(alu_ctrl);
    assign accept     = mdu_op && (state == ST_IDLE) && !flush;
    assign is_mul     = (alu_ctrl <= ALU_MULHU);
    assign div_signed = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_REM);
    assign want_rem   = (alu_ctrl == ALU_REM) || (alu_ctrl == ALU_REMU);
    assign div_zero   = (operand_b == '0);
    assign div_ovf    = div_signed && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    assign short_cut  = (DIV_SHORT != 0) && !is_mul && (div_zero || div_ovf);
    assign short_val  = div_zero ? (want_rem ? operand_a : '1) : (want_rem ? '0 : operand_a);

    // The accept edge (MUL_STAGES=1) multiplies live operands; later stages use the latched copy.
    logic [4:0]        mul_op;
    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic              sa, sb;
    logic [2*XLEN-1:0] ext_a, ext_b, product;

    assign mul_op  = (state == ST_IDLE) ? alu_ctrl  : op_q;
    assign mul_a   = (state == ST_IDLE) ? operand_a : a_q;
    assign mul_b   = (state == ST_IDLE) ? operand_b : b_q;
    assign sa      = (mul_op == ALU_MULH) || (mul_op == ALU_MULHSU);
    assign sb      = (mul_op == ALU_MULH);
    assign ext_a   = {{XLEN{sa & mul_a[XLEN-1]}}, mul_a};
    assign ext_b   = {{XLEN{sb & mul_b[XLEN-1]}}, mul_b};
    assign product = ext_a * ext_b;
    assign mul_res = (mul_op == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    logic            div_done;
    logic [XLEN-1:0] div_quot, div_rem;

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && !is_mul && !short_cut),
        .clear     (flush),
        .is_signed (div_signed),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    logic            res_load;
    logic [XLEN-1:0] res_nx;

    always_comb begin
        state_nx = state;
        res_load = 1'b0;
        res_nx   = md_result;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        if (MUL_STAGES <= 1) begin
                            state_nx = ST_DONE;
                            res_load = 1'b1;
                            res_nx   = mul_res;
                        end else begin
                            state_nx = ST_MUL;
                        end
                    end else if (short_cut) begin
                        state_nx = ST_DONE;
                        res_load = 1'b1;
                        res_nx   = short_val;
                    end else begin
                        state_nx = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (mul_cnt == MUL_LAST) begin
                    state_nx = ST_DONE;
                    res_load = 1'b1;
                    res_nx   = mul_res;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_nx = ST_DONE;
                    res_load = 1'b1;
                    res_nx   = (op_q == ALU_REM || op_q == ALU_REMU) ? div_rem : div_quot;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) begin
            state_nx = ST_IDLE;
            res_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            md_result <= '0;
            mul_cnt   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state <= state_nx;
            if (res_load) md_result <= res_nx;
            mul_cnt <= (state == ST_MUL && state_nx == ST_MUL) ? mul_cnt + 1'b1 : 2'd0;
            if (accept) begin
                op_q <= alu_ctrl;
                a_q  <= operand_a;
                b_q  <= operand_b;
            end
        end
    end

    assign md_valid = (state == ST_DONE);
    assign md_stall = (mdu_op && state == ST_IDLE) || state == ST_MUL || state == ST_DIV;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// tb/tb_alu_mdu_ctrl.sv - self-checking bench for alu_mdu_ctrl against a latency/arithmetic model
module tb_alu_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  func7 = '0;
    logic [2:0]  func3 = '0;
    logic [2:0]  aluop = '0;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;

    logic [4:0]  alu_ctrl, alu_ctrl2;
    logic        md_stall, md_valid, md_stall2, md_valid2;
    logic [31:0] md_result, md_result2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mdu_ctrl #(.XLEN(32), .MUL_STAGES(2), .M_EXT(1), .DIV_SHORT(1)) dut (
        .clk(clk), .rst(rst), .func7(func7), .func3(func3), .aluop(aluop),
        .valid_in(valid_in), .flush(flush), .operand_a(operand_a), .operand_b(operand_b),
        .alu_ctrl(alu_ctrl), .md_stall(md_stall), .md_valid(md_valid), .md_result(md_result)
    );

    alu_mdu_ctrl #(.XLEN(32), .MUL_STAGES(2), .M_EXT(0), .DIV_SHORT(1)) dut_m0 (
        .clk(clk), .rst(rst), .func7(func7), .func3(func3), .aluop(aluop),
        .valid_in(valid_in), .flush(flush), .operand_a(operand_a), .operand_b(operand_b),
        .alu_ctrl(alu_ctrl2), .md_stall(md_stall2), .md_valid(md_valid2), .md_result(md_result2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32IM decode from the instruction-set tables.
    function automatic logic [4:0] m_decode(input logic [2:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input bit mext);
        logic [4:0] rbase [0:7];
        rbase = '{5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd1, 5'd0};
        if (op == 3'd1 || op == 3'd2) return 5'd2;
        if (op == 3'd0) begin
            if (f7 == 7'h00) return rbase[f3];
            if (f7 == 7'h20 && f3 == 3'd0) return 5'd3;
            if (f7 == 7'h20 && f3 == 3'd5) return 5'd9;
            if (f7 == 7'h01 && mext) return 5'd10 + 5'(f3);
            return 5'd31;
        end
        if (op == 3'd3) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? 5'd4 : 5'd31;
            if (f3 == 3'd5) return (f7 == 7'h00) ? 5'd8 : (f7 == 7'h20) ? 5'd9 : 5'd31;
            return rbase[f3];
        end
        return 5'd31;
    endfunction

    function automatic bit m_is_md(input logic [4:0] c);
        return c >= 5'd10 && c <= 5'd17;
    endfunction

    function automatic logic [31:0] m_result(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int q;
        bit ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            5'd10: begin p = sa * sb; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * ub; return p[63:32]; end
            5'd13: begin p = ua * ub; return p[63:32]; end
            5'd14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int m_latency(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c <= 5'd13) return 2;
        if (b == 0) return 1;
        if ((c == 5'd14 || c == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Model: cycles remaining until the result, a done flag, and the held result.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [4:0] c;
        int lat;
        if (rst) begin
            m_busy = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            c = m_decode(aluop, func3, func7, 1'b1);
            if (flush) begin
                m_busy = 0;
                m_done = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (valid_in && m_is_md(c)) begin
                m_pend = m_result(c, operand_a, operand_b);
                lat = m_latency(c, operand_a, operand_b);
                if (lat == 1) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end else begin
                    m_busy = lat - 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [4:0] c1, c2;
        bit exp_stall;
        c1 = m_decode(aluop, func3, func7, 1'b1);
        c2 = m_decode(aluop, func3, func7, 1'b0);
        exp_stall = (m_busy > 0) || (!m_done && valid_in && m_is_md(c1));
        chk("cyc_ctrl", 32'(alu_ctrl), 32'(c1));
        chk("cyc_valid", 32'(md_valid), 32'(m_done));
        chk("cyc_stall", 32'(md_stall), 32'(exp_stall));
        chk("cyc_result", md_result, m_res);
        chk("cyc_ctrl_m0", 32'(alu_ctrl2), 32'(c2));
        chk("cyc_stall_m0", 32'(md_stall2), 32'(valid_in && m_is_md(c2)));
        chk("cyc_valid_m0", 32'(md_valid2), 32'(0));
    end

    task automatic run_op(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, output int lat, output int stalls);
        bit fin;
        fin = 1'b0;
        lat = -1;
        stalls = 0;
        aluop = op; func3 = f3; func7 = f7; operand_a = a; operand_b = b; valid_in = 1'b1;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            if (md_valid) lat = c;
            if (md_stall) stalls++;
            else fin = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        chk("op_retired", 32'(fin), 32'(1));
    endtask

    task automatic mdu(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
        int lat, st;
        run_op(3'd0, f3, 7'h01, a, b, lat, st);
        chk({name, "_result"}, md_result, exp_res);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_stalls"}, 32'(st), 32'(exp_lat));
    endtask

    initial begin
        int lat, st;
        #1;
        chk("reset_result", md_result, 32'h0);
        chk("reset_valid", 32'(md_valid), 32'(0));
        chk("reset_stall", 32'(md_stall), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int op = 0; op < 8; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f7 = 0; f7 < 128; f7++) begin
                    aluop = 3'(op); func3 = 3'(f3); func7 = 7'(f7);
                    #1;
                    chk("sweep_ctrl", 32'(alu_ctrl), 32'(m_decode(aluop, func3, func7, 1'b1)));
                    chk("sweep_ctrl_m0", 32'(alu_ctrl2), 32'(m_decode(aluop, func3, func7, 1'b0)));
                end

        aluop = 3'd0; func3 = 3'd5; func7 = 7'h20; #1;
        chk("dec_sra", 32'(alu_ctrl), 32'h09);
        func7 = 7'h03; #1;
        chk("dec_f7_bad", 32'(alu_ctrl), 32'h1F);
        aluop = 3'd3; func3 = 3'd1; func7 = 7'h20; #1;
        chk("dec_slli_bad", 32'(alu_ctrl), 32'h1F);
        aluop = 3'd2; #1;
        chk("dec_jalr", 32'(alu_ctrl), 32'h02);
        aluop = 3'd0; func3 = 3'd7; func7 = 7'h01; #1;
        chk("dec_remu", 32'(alu_ctrl), 32'h11);
        chk("dec_remu_m0", 32'(alu_ctrl2), 32'h1F);
        @(posedge clk); #1;

        mdu("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
        mdu("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 2);
        mdu("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
        mdu("mul",    3'd0, 32'd6,         32'd7, 32'd42,        2);
        mdu("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        mdu("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        mdu("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        mdu("rem0",   3'd6, 32'd5, 32'd0, 32'd5, 1);
        mdu("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        mdu("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        mdu("divu",   3'd5, 32'd100, 32'd7, 32'd14, 33);
        mdu("remu",   3'd7, 32'd100, 32'd7, 32'd2, 33);

        run_op(3'd0, 3'd0, 7'h00, 32'd9, 32'd9, lat, st);
        chk("add_no_stall", 32'(st), 32'(0));
        chk("add_no_valid", 32'(lat), 32'hFFFF_FFFF);
        chk("add_result_held", md_result, 32'd2);

        // Flush at divide cycle 10, then a MUL is presented the next cycle.
        aluop = 3'd0; func7 = 7'h01; func3 = 3'd4; operand_a = 32'd100; operand_b = 32'd7; valid_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; func3 = 3'd0; operand_a = 32'd6; operand_b = 32'd7;
        @(negedge clk);
        chk("flush_no_valid", 32'(md_valid), 32'(0));
        chk("flush_result_held", md_result, 32'd2);
        chk("flush_new_accept", 32'(md_stall), 32'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_mul_valid", 32'(md_valid), 32'(1));
        chk("flush_mul_result", md_result, 32'd42);
        @(posedge clk); #1 valid_in = 1'b0;
        @(posedge clk); #1;

        // Flush in the same cycle as an MDU op in IDLE prevents the accept.
        func3 = 3'd5; operand_a = 32'd50; operand_b = 32'd5; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_beats_accept", 32'(md_stall), 32'(0));
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        func3 = 3'd4; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2; valid_in = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1; valid_in = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(md_valid), 32'(0));
        chk("rst_mid_stall", 32'(md_stall), 32'(0));
        chk("rst_mid_result", md_result, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // M_EXT=0 instance: MUL is an invalid op and never stalls.
        func3 = 3'd0; func7 = 7'h01; operand_a = 32'd3; operand_b = 32'd4; valid_in = 1'b1;
        #1;
        chk("m0_mul_ctrl", 32'(alu_ctrl2), 32'h1F);
        chk("m0_mul_stall", 32'(md_stall2), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("m0_mul_valid", 32'(md_valid2), 32'(0));
        chk("m0_mul_result", md_result2, 32'h0);
        valid_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
